rv32_mod_regfile_sb: RTL

Integer register file with an attached issue scoreboard. It sits directly upstream of the ALU and drives its two operand inputs, read0_data and read1_data. It tracks destination registers owned by in-flight multi-cycle producers (loads, future mul/div) and raises stall on RAW/WAW hazards. Writeback from any producer enters through a single write port, with same-cycle bypass to the read ports.

---
 rtl/rv32_pkg.sv | 12 +
 rtl/rv32_mod_scoreboard.sv | 78 +++++++
 rtl/rv32_mod_regfile_sb.sv | 86 ++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared types and helpers for the rv32 register file and scoreboard.
// Holds register index / data types and the index range check.
package rv32_pkg;
    localparam int XLEN = 32;
    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;
    localparam reg_idx_t REG_ZERO = 5'd0;

    function automatic logic idx_ok(input reg_idx_t a, input int n);
        return (a != REG_ZERO) && (32'(a) < n);
    endfunction
endpackage

// File: rtl/rv32_mod_scoreboard.sv
// Busy tracking for long-latency destinations and issue stall logic.
// Bits for x0 and indices at or above NUM_REGS are never set.
module rv32_mod_scoreboard
    import rv32_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  reg_idx_t   rs1_addr,
    input  reg_idx_t   rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic       issue_valid,
    input  reg_idx_t   issue_rd,
    input  logic       issue_rd_long,
    input  logic       wb_valid,
    input  reg_idx_t   wb_rd,
    output logic       stall,
    output logic       issue_fire,
    output logic [3:0] outstanding
);
    logic [31:0] busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] wb_hit;
    logic [31:0] eff_busy;
    logic        wb_clr;
    logic        full;
    logic        long_ok;
    logic        hazard;
    logic        set_busy;

    // Hazard detection; a writeback in this cycle resolves its register.
    always_comb begin
        wb_hit = '0;
        if (wb_valid && idx_ok(wb_rd, NUM_REGS)) begin
            wb_hit[wb_rd] = 1'b1;
        end
        eff_busy = busy_q & ~wb_hit;
        wb_clr   = |(busy_q & wb_hit);
        full     = (cnt_q == 4'(MAX_OUTSTANDING)) && !wb_clr;
        long_ok  = issue_rd_long && idx_ok(issue_rd, NUM_REGS);
        hazard   = (rs1_used && eff_busy[rs1_addr])
                || (rs2_used && eff_busy[rs2_addr])
                || (long_ok && (eff_busy[issue_rd] || full));
        stall      = issue_valid && hazard;
        issue_fire = issue_valid && !hazard;
        set_busy   = issue_fire && long_ok;
    end

    // Next busy vector and counter; a set on the cleared register wins.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (set_busy) begin
            busy_d[issue_rd] = 1'b1;
        end
        cnt_d = cnt_q;
        unique case ({set_busy, wb_clr})
            2'b10: if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
            2'b01: if (cnt_q != 4'h0) cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Scoreboard state, always reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign outstanding = cnt_q;
endmodule

// File: rtl/rv32_mod_regfile_sb.sv
// Integer register file with writeback bypass and issue scoreboard.
// Define RV32_REGFILE_RESET_EN to clear the data registers on reset.
module rv32_mod_regfile_sb
    import rv32_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic        rs1_used,
    input  logic        rs2_used,
    output logic [31:0] read0_data,
    output logic [31:0] read1_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_long,
    output logic        stall,
    output logic        issue_fire,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [3:0]  outstanding
);
    xlen_t regs_q [32];
    xlen_t regs_d [32];
    logic  wr_en;

    // Combinational operand reads with same-cycle writeback bypass.
    always_comb begin
        read0_data = '0;
        read1_data = '0;
        if (idx_ok(rs1_addr, NUM_REGS)) begin
            if (wb_valid && wb_rd == rs1_addr) read0_data = wb_data;
            else                               read0_data = regs_q[rs1_addr];
        end
        if (idx_ok(rs2_addr, NUM_REGS)) begin
            if (wb_valid && wb_rd == rs2_addr) read1_data = wb_data;
            else                               read1_data = regs_q[rs2_addr];
        end
    end

    // Next array contents from the single write port.
    always_comb begin
        wr_en  = wb_valid && idx_ok(wb_rd, NUM_REGS);
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wb_rd] = wb_data;
        end
    end

`ifdef RV32_REGFILE_RESET_EN
    // Data array with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end
`else
    // Data array without reset so it can map to plain flops or LUTRAM.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end
`endif

    rv32_mod_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rd_long (issue_rd_long),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .outstanding   (outstanding)
    );
endmodule
